// File: rtl/mkd_pkg.sv
// mkd_pkg: shared types and constant helpers for the multi-key debouncer
package mkd_pkg;
    typedef enum logic [1:0] {IDLE, HELD, REPEAT, LATCHED} key_state_t;
    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
    function automatic int tick_div(input int clk_freq);
        return clk_freq / 1000;
    endfunction
endpackage

// File: rtl/multi_key_debounce_if.sv
// multi_key_debounce_if: raw key pins in, conditioned levels and event pulses out
interface multi_key_debounce_if #(parameter int N_KEYS = 4);
    logic [N_KEYS-1:0] key_in, key_level, key_press, key_release, key_long, key_repeat;
    modport master (output key_in, input key_level, key_press, key_release, key_long, key_repeat);
    modport slave (input key_in, output key_level, key_press, key_release, key_long, key_repeat);
endinterface

// File: rtl/multi_key_debounce_channel.sv
// key_channel: one key - synchroniser, tick-based debounce, hold/repeat FSM and pulses
module key_channel
    import mkd_pkg::*;
#(
    parameter int ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);
    localparam int DW = clog2(DEBOUNCE_MS + 1);
    localparam int HW = clog2((LONG_MS > REPEAT_MS ? LONG_MS : REPEAT_MS) + 1);
    localparam logic IDLE_PIN = ACTIVE_LOW != 0;
    logic sync1, sync2, pressed_s, flip, rise, fall, long_n, repeat_n;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt, hold_n;
    key_state_t state, state_n;
    assign pressed_s = sync2 ^ IDLE_PIN;
    assign flip = pressed_s != key_level && tick && db_cnt == DW'(DEBOUNCE_MS - 1);
    assign rise = flip && pressed_s;
    assign fall = flip && !pressed_s;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync1       <= IDLE_PIN;
            sync2       <= IDLE_PIN;
            db_cnt      <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            sync1       <= key_in;
            sync2       <= sync1;
            db_cnt      <= (pressed_s == key_level || flip) ? '0 : tick ? db_cnt + 1'b1 : db_cnt;
            key_level   <= key_level ^ flip;
            key_press   <= rise;
            key_release <= fall;
            key_long    <= long_n;
            key_repeat  <= repeat_n;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
        end
    // a release overrides any hold terminal count landing in the same cycle
    always_comb begin
        state_n  = state;
        hold_n   = hold_cnt;
        long_n   = 1'b0;
        repeat_n = 1'b0;
        if (fall) begin
            state_n = IDLE;
            hold_n  = '0;
        end else
            case (state)
                IDLE: if (rise) begin
                    state_n = HELD;
                    hold_n  = '0;
                end
                HELD: if (tick) begin
                    long_n = hold_cnt == HW'(LONG_MS - 1);
                    hold_n = long_n ? '0 : hold_cnt + 1'b1;
                    if (long_n) state_n = REPEAT_MS != 0 ? REPEAT : LATCHED;
                end
                REPEAT: if (tick) begin
                    repeat_n = hold_cnt == HW'(REPEAT_MS - 1);
                    hold_n   = repeat_n ? '0 : hold_cnt + 1'b1;
                end
                default: ;
            endcase
    end
endmodule

// File: rtl/multi_key_debounce.sv
// multi_key_debounce: shared ms-tick prescaler driving N independent key channels
module multi_key_debounce
    import mkd_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int N_KEYS      = 4,
    parameter int ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input logic clk,
    input logic rst_n,
    multi_key_debounce_if.slave bus
);
    localparam int DIV = tick_div(CLK_FREQ);
    localparam int PW = clog2(DIV + 1);
    logic [PW-1:0] pre;
    logic tick;
    logic [N_KEYS-1:0] level, press, rel, long_p, repeat_p;
    assign tick = pre == PW'(DIV - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pre <= '0;
        else pre <= tick ? '0 : pre + 1'b1;
    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .ACTIVE_LOW(ACTIVE_LOW), .DEBOUNCE_MS(DEBOUNCE_MS),
            .LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)
        ) u_ch (
            .clk(clk), .rst_n(rst_n), .tick(tick), .key_in(bus.key_in[i]),
            .key_level(level[i]), .key_press(press[i]), .key_release(rel[i]),
            .key_long(long_p[i]), .key_repeat(repeat_p[i])
        );
    end
    assign bus.key_level   = level;
    assign bus.key_press   = press;
    assign bus.key_release = rel;
    assign bus.key_long    = long_p;
    assign bus.key_repeat  = repeat_p;
endmodule
